operand_stack: RTL and testbench
================================

Name: operand_stack

Overview:
- Hardware operand stack for the 16-bit stack machine; sits directly upstream of alu16b.
- Drives alu16b's A/B from the top two stack entries and writes alu16b's S back on commit.
- Counts depth, flags underflow/overflow, and holds a sticky copy of alu16b's OFL.

Parameters:
- WIDTH, 16, data width; matches alu16b.
- DEPTH, 16, number of stack entries.
- PTR_W, 4, log2(DEPTH); depth counter is PTR_W+1 bits.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Op  input  3  0 NOP, 1 PUSH, 2 POP, 3 BINOP, 4 UNOP, 5 DUP, 6 SWAP, 7 NOP.
- Din  input  WIDTH  PUSH data.
- AluS  input  WIDTH  alu16b S, combinational this cycle.
- AluOFL  input  1  alu16b OFL.
- ClrErr  input  1  clears Err and OflSticky.
- AluA  output  WIDTH  to alu16b A: NOS normally, TOS when Op=UNOP.
- AluB  output  WIDTH  to alu16b B: TOS.
- Tos  output  WIDTH  top entry; 0 when Count=0.
- Nos  output  WIDTH  second entry; 0 when Count<2.
- Count  output  PTR_W+1  current depth, 0..DEPTH.
- Empty  output  1  Count==0.
- Full  output  1  Count==DEPTH.
- Err  output  1  sticky illegal-op flag.
- OflSticky  output  1  sticky ALU overflow flag.

Behaviour:
- Reset (async, any time, including mid-operation) sets Count=0, Err=0, OflSticky=0. Storage array is not reset; Tos, Nos, AluA and AluB read 0 through Count gating.
- All ops commit on the rising CLK edge. Results are visible on outputs the following cycle; no multi-cycle ops, no stall.
- AluA and AluB are combinational from current state and Op. The ALU result is consumed in the same cycle as the op.
- Op semantics:
  - PUSH: mem[Count]=Din; Count+1.
  - POP: Count-1; data discarded.
  - BINOP: mem[Count-2]=AluS; Count-1. Computes NOS op TOS, so push a, push b, SUB yields a-b.
  - UNOP: mem[Count-1]=AluS; Count unchanged. Used for NOT and NEG.
  - DUP: mem[Count]=mem[Count-1]; Count+1.
  - SWAP: exchange mem[Count-1] and mem[Count-2].
- Legality preconditions:
  - PUSH and DUP need Count<DEPTH.
  - POP and UNOP need Count>=1.
  - BINOP and SWAP need Count>=2.
- An illegal op makes no change to Count or storage and sets Err=1. Err holds until Reset or ClrErr.
- OflSticky is set when a legal BINOP or UNOP commits with AluOFL=1. AluOFL is ignored for all other ops and for illegal ops.
- ClrErr in the same cycle as a new error or new overflow: the set wins, and the flag stays 1.
- Count never wraps: 0 minus 1 and DEPTH plus 1 are always blocked as illegal.
- Op codes 0 and 7 hold all state.

Decomposition:
- Shared package stack_pkg holds:
  - opcode constants OP_NOP..OP_SWAP;
  - WIDTH default;
  - ALUop encodings (ADD=0, SUB=1, SLL=2, SRL=3, AND=4, OR=5, XOR=6, NOT=7, NEG=9) for the decode stage and benches.
- One sub-module, stack_regfile: DEPTH x WIDTH register array with two async read ports (Count-1, Count-2), one write port, and a swap path.
- operand_stack holds the counter, legality checks, flags and output muxing.

Test Plan (bench instantiates operand_stack wired to alu16b):
- Reset, PUSH 500, PUSH 600, BINOP with ALUop=1 -> Tos=16'hFF9C (-100), Count=1, Err=0, OflSticky=0.
- Reset, PUSH 32767, PUSH 1, BINOP with ALUop=0 -> Tos=16'h8000, OflSticky=1. Then ClrErr -> OflSticky=0.
- Reset, PUSH 7000, UNOP with ALUop=9 -> Tos=16'hE4A8, Count=1. Then UNOP with ALUop=7 -> Tos=16'h1B57.
- Reset, PUSH 3, PUSH 5, SWAP -> Tos=3, Nos=5. Then DUP -> Count=3, Tos=3. Then POP x3 -> Empty=1. Then POP -> Err=1, Count=0.
- Reset, PUSH 1..16 -> Full=1, Tos=16. Then PUSH 99 -> Err=1, Count=16, Tos=16. Then BINOP with Count=1 after 15 POPs -> Err stays 1, Tos unchanged.
- PUSH 4 times, assert Reset asynchronously mid-cycle with Op=PUSH -> Count=0 immediately, no commit that edge. Tos=0, Err=0 after release.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the 16-bit stack machine: opcodes, data width and
// the alu16b operation encodings used by the decode stage and benches.
package stack_pkg;

   localparam int STACK_WIDTH = 16;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_PUSH  = 3'd1,
      OP_POP   = 3'd2,
      OP_BINOP = 3'd3,
      OP_UNOP  = 3'd4,
      OP_DUP   = 3'd5,
      OP_SWAP  = 3'd6,
      OP_NOP7  = 3'd7
   } op_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_SLL = 4'd2,
      ALU_SRL = 4'd3,
      ALU_AND = 4'd4,
      ALU_OR  = 4'd5,
      ALU_XOR = 4'd6,
      ALU_NOT = 4'd7,
      ALU_NEG = 4'd9
   } alu_op_e;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x WIDTH registers, async reads of the top two slots,
// one write port and an in-place exchange of the two read slots.
module stack_regfile
   import stack_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic [PTR_W-1:0] rd_top_idx,
   input  logic [PTR_W-1:0] rd_nos_idx,
   input  logic             we,
   input  logic [PTR_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             swap,
   output logic [WIDTH-1:0] rd_top_data,
   output logic [WIDTH-1:0] rd_nos_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   assign rd_top_data = mem_q[rd_top_idx];
   assign rd_nos_data = mem_q[rd_nos_idx];

   // Write and swap are never requested together; swap uses the read slots.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[wr_idx] = wr_data;
      end
      if (swap) begin
         mem_d[rd_top_idx] = mem_q[rd_nos_idx];
         mem_d[rd_nos_idx] = mem_q[rd_top_idx];
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/operand_stack.sv
// Operand stack feeding alu16b: depth counter, legality checks, sticky
// error/overflow flags and the TOS/NOS output muxing.
module operand_stack
   import stack_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] Din,
   input  logic [WIDTH-1:0] AluS,
   input  logic             AluOFL,
   input  logic             ClrErr,
   output logic [WIDTH-1:0] AluA,
   output logic [WIDTH-1:0] AluB,
   output logic [WIDTH-1:0] Tos,
   output logic [WIDTH-1:0] Nos,
   output logic [PTR_W:0]   Count,
   output logic             Empty,
   output logic             Full,
   output logic             Err,
   output logic             OflSticky
);

   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   op_e              op;
   logic [PTR_W:0]   count_q, count_d;
   logic             err_q, err_d;
   logic             ofl_q, ofl_d;

   logic [PTR_W-1:0] idx_top, idx_nos;
   logic [WIDTH-1:0] rd_top, rd_nos;
   logic             we, swap, illegal, alu_commit;
   logic [PTR_W-1:0] wr_idx;
   logic [WIDTH-1:0] wr_data;
   logic             has1, has2, not_full;

   assign op       = op_e'(Op);
   assign idx_top  = count_q[PTR_W-1:0] - PTR_W'(1);
   assign idx_nos  = count_q[PTR_W-1:0] - PTR_W'(2);
   assign has1     = (count_q != '0);
   assign has2     = (count_q > CNT_ONE);
   assign not_full = (count_q != CNT_FULL);

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_regfile (
      .clk         (CLK),
      .rd_top_idx  (idx_top),
      .rd_nos_idx  (idx_nos),
      .we          (we),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .swap        (swap),
      .rd_top_data (rd_top),
      .rd_nos_data (rd_nos)
   );

   always_comb begin
      count_d    = count_q;
      we         = 1'b0;
      swap       = 1'b0;
      wr_idx     = idx_top;
      wr_data    = AluS;
      illegal    = 1'b0;
      alu_commit = 1'b0;
      unique case (op)
         OP_PUSH: begin
            if (not_full) begin
               we      = 1'b1;
               wr_idx  = count_q[PTR_W-1:0];
               wr_data = Din;
               count_d = count_q + CNT_ONE;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_POP: begin
            if (has1) count_d = count_q - CNT_ONE;
            else      illegal = 1'b1;
         end
         OP_BINOP: begin
            if (has2) begin
               we         = 1'b1;
               wr_idx     = idx_nos;
               count_d    = count_q - CNT_ONE;
               alu_commit = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_UNOP: begin
            if (has1) begin
               we         = 1'b1;
               alu_commit = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_DUP: begin
            if (has1 && not_full) begin
               we      = 1'b1;
               wr_idx  = count_q[PTR_W-1:0];
               wr_data = rd_top;
               count_d = count_q + CNT_ONE;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_SWAP: begin
            if (has2) swap    = 1'b1;
            else      illegal = 1'b1;
         end
         default: ;
      endcase

      // A new set in the same cycle as ClrErr wins.
      err_d = (err_q & ~ClrErr) | illegal;
      ofl_d = (ofl_q & ~ClrErr) | (alu_commit & AluOFL);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
         err_q   <= 1'b0;
         ofl_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
         ofl_q   <= ofl_d;
      end
   end

   assign Tos       = has1 ? rd_top : '0;
   assign Nos       = has2 ? rd_nos : '0;
   assign AluB      = Tos;
   assign AluA      = (op == OP_UNOP) ? Tos : Nos;
   assign Count     = count_q;
   assign Empty     = ~has1;
   assign Full      = ~not_full;
   assign Err       = err_q;
   assign OflSticky = ofl_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack with a behavioural alu16b stand-in
// closing the A/B -> S/OFL loop.
module tb_operand_stack;
   import stack_pkg::*;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic [2:0]  Op = 3'd0;
   logic [15:0] Din = '0;
   logic [15:0] AluS;
   logic        AluOFL;
   logic        ClrErr = 1'b0;
   logic [15:0] AluA, AluB, Tos, Nos;
   logic [4:0]  Count;
   logic        Empty, Full, Err, OflSticky;
   alu_op_e     alu_op = ALU_ADD;

   int checks = 0;
   int failures = 0;

   operand_stack #(.WIDTH(16), .DEPTH(16), .PTR_W(4)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Op        (Op),
      .Din       (Din),
      .AluS      (AluS),
      .AluOFL    (AluOFL),
      .ClrErr    (ClrErr),
      .AluA      (AluA),
      .AluB      (AluB),
      .Tos       (Tos),
      .Nos       (Nos),
      .Count     (Count),
      .Empty     (Empty),
      .Full      (Full),
      .Err       (Err),
      .OflSticky (OflSticky)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      AluS   = '0;
      AluOFL = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            AluS   = AluA + AluB;
            AluOFL = (AluA[15] == AluB[15]) && (AluS[15] != AluA[15]);
         end
         ALU_SUB: begin
            AluS   = AluA - AluB;
            AluOFL = (AluA[15] != AluB[15]) && (AluS[15] != AluA[15]);
         end
         ALU_SLL: AluS = AluA << AluB[3:0];
         ALU_SRL: AluS = AluA >> AluB[3:0];
         ALU_AND: AluS = AluA & AluB;
         ALU_OR:  AluS = AluA | AluB;
         ALU_XOR: AluS = AluA ^ AluB;
         ALU_NOT: AluS = ~AluA;
         ALU_NEG: begin
            AluS   = 16'd0 - AluA;
            AluOFL = (AluA == 16'h8000);
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [2:0] op, input logic [15:0] d,
                       input alu_op_e aop, input logic clr);
      @(negedge CLK);
      Op     = op;
      Din    = d;
      alu_op = aop;
      ClrErr = clr;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      Op     = OP_NOP;
      ClrErr = 1'b0;
      Reset  = 1'b1;
      @(posedge CLK);
      #1;
      Reset = 1'b0;
   endtask

   initial begin
      // Scenario 1: subtraction order
      do_reset();
      check("rst_count", Count, 5'd0);
      check("rst_tos", Tos, 16'h0);
      check("rst_nos", Nos, 16'h0);
      check("rst_empty", Empty, 1'b1);
      check("rst_err", Err, 1'b0);
      check("rst_ofl", OflSticky, 1'b0);
      step(OP_PUSH, 16'd500, ALU_ADD, 1'b0);
      step(OP_PUSH, 16'd600, ALU_ADD, 1'b0);
      check("s1_nos", Nos, 16'd500);
      step(OP_BINOP, 16'd0, ALU_SUB, 1'b0);
      check("s1_tos", Tos, 16'hFF9C);
      check("s1_count", Count, 5'd1);
      check("s1_err", Err, 1'b0);
      check("s1_ofl", OflSticky, 1'b0);

      // Scenario 2: overflow sticky, clear, set-wins
      do_reset();
      step(OP_PUSH, 16'd32767, ALU_ADD, 1'b0);
      step(OP_PUSH, 16'd1, ALU_ADD, 1'b0);
      step(OP_BINOP, 16'd0, ALU_ADD, 1'b0);
      check("s2_tos", Tos, 16'h8000);
      check("s2_ofl", OflSticky, 1'b1);
      step(OP_NOP, 16'd0, ALU_ADD, 1'b1);
      check("s2_clr_ofl", OflSticky, 1'b0);
      step(OP_UNOP, 16'd0, ALU_NEG, 1'b1);
      check("s2_setwins_ofl", OflSticky, 1'b1);
      check("s2_neg_tos", Tos, 16'h8000);
      step(OP_NOP, 16'd0, ALU_ADD, 1'b1);
      check("s2_clr2_ofl", OflSticky, 1'b0);

      // Scenario 3: unary ops and opcode 7
      do_reset();
      step(OP_PUSH, 16'd7000, ALU_ADD, 1'b0);
      step(OP_UNOP, 16'd0, ALU_NEG, 1'b0);
      check("s3_neg_tos", Tos, 16'hE4A8);
      check("s3_count", Count, 5'd1);
      step(OP_UNOP, 16'd0, ALU_NOT, 1'b0);
      check("s3_not_tos", Tos, 16'h1B57);
      step(OP_NOP7, 16'h1234, ALU_ADD, 1'b0);
      check("s3_op7_tos", Tos, 16'h1B57);
      check("s3_op7_count", Count, 5'd1);
      check("s3_op7_err", Err, 1'b0);

      // Scenario 4: swap, dup, pop, underflow with ClrErr
      do_reset();
      step(OP_PUSH, 16'd3, ALU_ADD, 1'b0);
      step(OP_PUSH, 16'd5, ALU_ADD, 1'b0);
      step(OP_SWAP, 16'd0, ALU_ADD, 1'b0);
      check("s4_swap_tos", Tos, 16'd3);
      check("s4_swap_nos", Nos, 16'd5);
      step(OP_DUP, 16'd0, ALU_ADD, 1'b0);
      check("s4_dup_count", Count, 5'd3);
      check("s4_dup_tos", Tos, 16'd3);
      check("s4_dup_nos", Nos, 16'd3);
      step(OP_POP, 16'd0, ALU_ADD, 1'b0);
      step(OP_POP, 16'd0, ALU_ADD, 1'b0);
      check("s4_pop2_tos", Tos, 16'd5);
      step(OP_POP, 16'd0, ALU_ADD, 1'b0);
      check("s4_empty", Empty, 1'b1);
      check("s4_err_clean", Err, 1'b0);
      step(OP_POP, 16'd0, ALU_ADD, 1'b1);
      check("s4_under_err", Err, 1'b1);
      check("s4_under_count", Count, 5'd0);
      check("s4_under_tos", Tos, 16'd0);

      // Scenario 5: fill, overflow push, illegal binop at depth 1
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         step(OP_PUSH, 16'(i), ALU_ADD, 1'b0);
      end
      check("s5_full", Full, 1'b1);
      check("s5_tos", Tos, 16'd16);
      check("s5_nos", Nos, 16'd15);
      check("s5_count", Count, 5'd16);
      step(OP_PUSH, 16'd99, ALU_ADD, 1'b0);
      check("s5_ovf_err", Err, 1'b1);
      check("s5_ovf_count", Count, 5'd16);
      check("s5_ovf_tos", Tos, 16'd16);
      for (int i = 0; i < 15; i++) begin
         step(OP_POP, 16'd0, ALU_ADD, 1'b0);
      end
      check("s5_pop_count", Count, 5'd1);
      check("s5_pop_tos", Tos, 16'd1);
      step(OP_BINOP, 16'd0, ALU_ADD, 1'b0);
      check("s5_bin_err", Err, 1'b1);
      check("s5_bin_tos", Tos, 16'd1);
      check("s5_bin_count", Count, 5'd1);

      // Scenario 6: async reset mid-cycle with a PUSH pending (Err still 1)
      for (int i = 0; i < 4; i++) begin
         step(OP_PUSH, 16'(100 + i), ALU_ADD, 1'b0);
      end
      check("s6_count", Count, 5'd5);
      @(negedge CLK);
      Op  = OP_PUSH;
      Din = 16'd77;
      #2;
      Reset = 1'b1;
      #1;
      check("s6_async_count", Count, 5'd0);
      check("s6_async_err", Err, 1'b0);
      @(posedge CLK);
      #1;
      check("s6_held_count", Count, 5'd0);
      @(negedge CLK);
      Reset = 1'b0;
      Op    = OP_NOP;
      #1;
      check("s6_rel_tos", Tos, 16'd0);
      check("s6_rel_err", Err, 1'b0);
      check("s6_rel_count", Count, 5'd0);
      step(OP_PUSH, 16'd42, ALU_ADD, 1'b0);
      check("s6_push_tos", Tos, 16'd42);
      check("s6_push_count", Count, 5'd1);

      @(negedge CLK);
      Op = OP_NOP;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
